// File: rtl/alu_seq_pkg.sv
// Shared widths, ALU opcode encodings and sequencer FSM state type.
package alu_seq_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = 5;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned CNT_W  = 4;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_MIN  = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd12;
   localparam logic [3:0] OP_NAND = 4'd13;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } seq_state_t;

endpackage

// File: rtl/alu_sequencer_reg_file.sv
// 32x32 register file: two operand read ports, one debug read port, one write
// port. Index 0 always reads as zero and ignores writes.
module reg_file
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  rd_addr1,
   output logic [DATA_W-1:0] rd_data1,
   input  logic [IDX_W-1:0]  rd_addr2,
   output logic [DATA_W-1:0] rd_data2,
   input  logic [IDX_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem [NREGS];

   // Storage: cleared asynchronously by reset, single write port, index 0 discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (wr_addr != '0)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
   assign rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];
   assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue sequencer: reads operands from the register file, presents them
// to an external ALU, waits ALU_LAT cycles and writes the result back.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned ALU_LAT = 1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [IDX_W-1:0]  instr_rs1,
   input  logic [IDX_W-1:0]  instr_rs2,
   input  logic [IDX_W-1:0]  instr_rd,
   output logic [3:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_input1,
   output logic [DATA_W-1:0] alu_input2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              ld_en,
   input  logic [IDX_W-1:0]  ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              wb_valid,
   output logic [IDX_W-1:0]  wb_rd,
   output logic [DATA_W-1:0] wb_data,
   input  logic [IDX_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  rd_q;
   logic              accept;
   logic              wb_fire;
   logic [DATA_W-1:0] rs1_data, rs2_data;
   logic              rf_we;
   logic [IDX_W-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   assign instr_ready = (state_q == ST_IDLE) && rst_n;

   // Next-state and countdown: accept in IDLE, count down in EXEC, retire at zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      wb_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid && instr_ready) begin
               accept  = 1'b1;
               cnt_d   = CNT_W'(ALU_LAT);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               wb_fire = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write-port arbitration: writeback owns the port when it targets a real
   // register; a writeback to R0 is discarded, so a same-edge preload still lands.
   always_comb begin
      rf_we    = ld_en;
      rf_waddr = ld_addr;
      rf_wdata = ld_data;
      if (wb_fire && (rd_q != '0)) begin
         rf_we    = 1'b1;
         rf_waddr = rd_q;
         rf_wdata = alu_result;
      end
   end

   // FSM state and countdown register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ALU operand capture on accept and one-cycle writeback notification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode <= '0;
         alu_input1 <= '0;
         alu_input2 <= '0;
         rd_q       <= '0;
         wb_valid   <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
      end else begin
         wb_valid <= wb_fire;
         if (accept) begin
            alu_opcode <= instr_op;
            alu_input1 <= rs1_data;
            alu_input2 <= rs2_data;
            rd_q       <= instr_rd;
         end
         if (wb_fire) begin
            wb_rd   <= rd_q;
            wb_data <= alu_result;
         end
      end
   end

   reg_file u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr1 (instr_rs1),
      .rd_data1 (rs1_data),
      .rd_addr2 (instr_rs2),
      .rd_data2 (rs2_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (rf_we),
      .wr_addr  (rf_waddr),
      .wr_data  (rf_wdata)
   );

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter ALU_LAT, default 1, meaning cycles from ALU operand capture to a valid alu_result; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  sequencer can accept an instruction.
REQ-006 instr_op  input  4  ALU opcode for the instruction.
REQ-007 instr_rs1, instr_rs2, instr_rd  input  5 each  source and destination register indices.
REQ-008 alu_opcode  output  4  opcode to downstream ALU.
REQ-009 alu_input1, alu_input2  output  32 each  operands to ALU.
REQ-010 alu_result  input  32  registered result from ALU.
REQ-011 ld_en, ld_addr, ld_data  input  1/5/32  host register preload port.
REQ-012 wb_valid, wb_rd, wb_data  output  1/5/32  one-cycle writeback notification.
REQ-013 dbg_addr  input  5; dbg_data  output  32  combinational register peek.

Function
REQ-014 FSM states SHALL be IDLE and EXEC only.
REQ-015 instr_ready SHALL be 1 exactly when state is IDLE and rst_n is high.
REQ-016 Accept = instr_valid & instr_ready at a rising edge; at that edge alu_opcode<=instr_op, alu_input1<=R[rs1], alu_input2<=R[rs2], rd latched, counter<=ALU_LAT, state<=EXEC.
REQ-017 instr_* SHALL be ignored when instr_ready is 0; no buffering.
REQ-018 alu_* outputs SHALL hold stable for the entire EXEC period and until the next accept.
REQ-019 In EXEC the counter SHALL decrement each cycle; at the edge where counter==0, alu_result SHALL be written to R[rd], state<=IDLE.
REQ-020 Latency: accept at edge t -> register write and IDLE at edge t+1+ALU_LAT; wb_valid high during cycle following that edge (one cycle only), with wb_rd=rd, wb_data=captured result.
REQ-021 R[0] SHALL read as 0; writes to index 0 from any source SHALL be discarded, but wb_valid still pulses with wb_data=alu_result.
REQ-022 Register reads SHALL be combinational from the array; an instruction accepted in the wb_valid cycle SHALL see the newly written value.
REQ-023 ld_en SHALL write ld_data to R[ld_addr] in any state.
REQ-024 Same-edge collision of ld write and writeback to same index: writeback SHALL win.
REQ-025 Same-edge ld write and accept reading that index: operand SHALL get the pre-write value.
REQ-026 dbg_data SHALL equal R[dbg_addr] combinationally (0 for index 0).
REQ-027 Throughput SHALL be one instruction per ALU_LAT+2 cycles maximum.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, all 31 registers 0, alu_opcode/alu_input1/alu_input2 0, wb_valid 0, wb_rd 0, wb_data 0.
REQ-029 Reset during EXEC SHALL abort the instruction with no register write and no wb_valid.
REQ-030 First accept SHALL be possible at the first rising edge after rst_n deasserts.

Structure
REQ-031 Package alu_seq_pkg SHALL hold: data width 32, register index width 5, opcode constants (AND 0, OR 1, ADD 2, SUB 6, MIN 7, NOR 12, NAND 13; others = pass input1), FSM state encoding.
REQ-032 Sub-module reg_file SHALL implement 32x32 storage with two async read ports, one debug read port, one write port; write-source arbitration (writeback over ld) SHALL live in alu_sequencer.

Verification
REQ-033 Reset then ld R1=5, R2=3; instr ADD rd=3 rs1=1 rs2=2 accepted at edge t, ALU model latency 1 -> alu_input1=5, alu_input2=3 from t; wb_valid at cycle after t+2 with wb_rd=3, wb_data=8; dbg R3=8.
REQ-034 instr_valid held high continuously with SUB R4=R3-R1 queued behind REQ-033 instr -> instr_ready low during EXEC, second accept in wb_valid cycle, operand1=8, wb_data=3.
REQ-035 ADD rd=0 rs1=1 rs2=2 -> wb_valid with wb_data=8, dbg R0 stays 0.
REQ-036 Writeback to R5 and ld_en R5=0xDEAD same edge -> R5 holds ALU result, not 0xDEAD.
REQ-037 ALU_LAT=4: accept at t -> write at t+5, instr_ready low for exactly 5 cycles.
REQ-038 rst_n pulsed low mid-EXEC -> no wb_valid, all registers 0, instr_ready high after release.
